mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU's single unified `Mem` port, which is shared between instruction fetch and load/store. It decides which requester owns each memory cycle and drives `MemRead`, `MemWrite`, `addr` and `data_in`. It tracks the one outstanding access so read data and completions are returned to the right requester one cycle later. It also counts contention cycles for performance analysis.

## Interface
Reset is asynchronous and active-low on `rst`. Clocking is a single clock, `clk`.

Parameters:
- `ADDR_W`, 7, memory byte-address width (matches `Mem.addr`)
- `DATA_W`, 32, data width
- `CNT_W`, 16, contention counter width

Ports:
- `clk`  in  1  the single clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_gnt`  out  1  fetch granted this cycle
- `if_rvalid`  out  1  fetch data valid (cycle after grant)
- `if_rdata`  out  DATA_W  instruction word
- `d_req`  in  1  data request; held with its attributes until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address (ALU result)
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request granted this cycle
- `d_rvalid`  out  1  load data valid, or store complete, in the cycle after the grant
- `d_rdata`  out  DATA_W  load data
- `mem_read`, `mem_write`  out  1  to `Mem.MemRead` / `Mem.MemWrite`
- `mem_addr`  out  ADDR_W  to `Mem.addr`
- `mem_wdata`  out  DATA_W  to `Mem.data_in`
- `mem_rdata`  in  DATA_W  from `Mem.data_out`; registered, valid one cycle after the read cycle
- `conflict_cnt`  out  CNT_W  saturating count of contention cycles

## Operation
- Arbitration is combinational, evaluated every cycle:
  - At most one grant per cycle.
  - A grant is issued whenever at least one request is high. There is no idle gap, so back-to-back grants are allowed.
- Grant cycle drive:
  - `mem_addr` takes the winner's address.
  - `mem_read` = winner is fetch, or winner is data with `!d_we`.
  - `mem_write` = winner is data with `d_we`.
  - `mem_wdata` = `d_wdata`.
  - With no grant, `mem_read` = `mem_write` = 0, `mem_addr` = 0 and `mem_wdata` = 0.
- Owner register (2 bits), updated on every posedge to the current cycle's winner: NONE, IF, DRD or DWR.
- Response cycle, driven from the owner register:
  - Owner IF: `if_rvalid` = 1 and `if_rdata` = `mem_rdata`.
  - Owner DRD: `d_rvalid` = 1 and `d_rdata` = `mem_rdata`.
  - Owner DWR: `d_rvalid` = 1 and `d_rdata` = 0.
  - Whenever the corresponding rvalid is low, `if_rdata` and `d_rdata` are 0.
- Default priority: data wins over fetch, because the current instruction's load/store must finish before the next fetch.
- Contention: a cycle with both `if_req` and `d_req` high increments `conflict_cnt` by 1. The count saturates at all-ones.

## Timing
- Reset (`rst` = 0, async): owner = NONE, last-winner = IF, `conflict_cnt` = 0.
  - All grants, rvalids, `mem_read` and `mem_write` are 0 while in reset.
  - Reset asserted mid-operation drops any pending response; no rvalid fires after release.
- Latency: grant in cycle N, response (rvalid/rdata) in cycle N+1. Throughput is one access per cycle.
- Requesters must hold their request and attributes stable until the grant. Changing them before the grant is illegal (no assertion required).
- Simultaneous response and new grant in cycle N+1 is legal and required to work.
- A requester that receives a grant deasserts or changes its request in the following cycle. A request still high after the grant is treated as a new request.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin. On a conflict, the winner is the requester that did not win the most recent conflict, held in the last-winner register.
  - The last-winner register resets to IF, so data wins the first conflict.
- Not defined: fixed data-over-fetch priority. The last-winner register is not instantiated.

## Structure
- Package `mem_arb_pkg` holds:
  - Owner encoding: `OWN_NONE` = 2'b00, `OWN_IF` = 2'b01, `OWN_DRD` = 2'b10, `OWN_DWR` = 2'b11.
  - Requester index constants: `REQ_IF` = 0, `REQ_D` = 1.
- One sub-module, `mem_arb_pick`:
  - Combinational two-way picker.
  - Inputs: the two requests and last-winner. Output: one-hot grant.
  - Contains the `MEM_ARB_RR_EN` selection.

## Test plan
- Reset mid-response: grant fetch, assert `rst` = 0 in the next cycle, then release. Expected: no `if_rvalid` ever, owner NONE, `conflict_cnt` = 0.
- Fetch only: `if_req` = 1, `if_addr` = 7'h08, memory word 0x00A00093. Expected: cycle N has `if_gnt` = 1, `mem_read` = 1, `mem_addr` = 0x08. Cycle N+1 has `if_rvalid` = 1, `if_rdata` = 0x00A00093.
- Store then load, back-to-back:
  - Store 0xDEADBEEF to 0x40: N has `d_gnt` and `mem_write` = 1, N+1 has `d_rvalid` = 1 and `d_rdata` = 0.
  - Load 0x40, granted in N+1: N+2 has `d_rdata` = 0xDEADBEEF.
- Conflict, `MEM_ARB_RR_EN` undefined: `if_req` = `d_req` = 1 for 3 cycles (data request renewed each cycle). Expected: data granted all 3 cycles, `conflict_cnt` = 3.
- Conflict, `MEM_ARB_RR_EN` defined: both requesting continuously for 4 cycles. Expected grants D, IF, D, IF, and the responses route to the matching rvalid one cycle later.
- Saturation: with `CNT_W` = 4, hold contention for 20 cycles. Expected: `conflict_cnt` stops at 4'hF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the unified memory-port arbiter.
//   owner_e : which requester owns the access whose response is due next
//             cycle (none, instruction fetch, data read, data write).
//   REQ_IF / REQ_D : bit positions of the fetch and data requester inside
//             the two-bit request/grant vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DRD  = 2'b10,
        OWN_DWR  = 2'b11
    } owner_e;

    localparam int REQ_IF = 0;
    localparam int REQ_D  = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational two-way picker for the shared memory port.
// Configuration macro: MEM_ARB_RR_EN
//   defined     : round-robin on conflicts, the requester that did not win
//                 the previous conflict wins this one.
//   not defined : fixed priority, data always beats fetch.
// Ports:
//   req_i      [1:0] requests, indexed by REQ_IF / REQ_D
//   last_win_i       winner of the most recent conflict (0 = fetch, 1 = data)
//   gnt_o      [1:0] one-hot (or zero) grant, same indexing as req_i
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_win_i,
    output logic [1:0] gnt_o
);

    // Data wins by default because the current instruction's load/store
    // has to complete before the next instruction can be fetched.
    always_comb begin
        gnt_o = 2'b00;
`ifdef MEM_ARB_RR_EN
        if (req_i[REQ_IF] && req_i[REQ_D]) begin
            if (last_win_i) begin
                gnt_o[REQ_IF] = 1'b1;
            end else begin
                gnt_o[REQ_D] = 1'b1;
            end
        end else begin
            gnt_o = req_i;
        end
`else
        if (req_i[REQ_D]) begin
            gnt_o[REQ_D] = 1'b1;
        end else if (req_i[REQ_IF]) begin
            gnt_o[REQ_IF] = 1'b1;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores the history input.
    logic unused_last_win;
    assign unused_last_win = last_win_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the single unified Mem port between instruction fetch and
// load/store, drives the memory control/address/data, routes the registered
// read data back to the owner one cycle after the grant, and counts cycles in
// which both requesters competed.
// Configuration macro: MEM_ARB_RR_EN (round-robin on conflicts; without it
// data has fixed priority and no last-winner register exists).
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata     fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   data requester
//   mem_read, mem_write, mem_addr, mem_wdata -> Mem;  mem_rdata <- Mem
//   conflict_cnt  saturating count of contention cycles
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]       reqVec;
    logic [1:0]       gnt;
    logic             conflict;
    logic             lastWinSel;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Requests are masked while reset is asserted so no grant or memory
    // strobe can escape during reset.
    assign reqVec[REQ_IF] = if_req & rst;
    assign reqVec[REQ_D]  = d_req & rst;
    assign conflict       = reqVec[REQ_IF] & reqVec[REQ_D];

`ifdef MEM_ARB_RR_EN
    logic lastWin_q, lastWin_d;

    // Only conflicts update the history; uncontested grants leave it alone.
    always_comb begin
        lastWin_d = lastWin_q;
        if (conflict) begin
            lastWin_d = gnt[REQ_D];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastWin_q <= 1'b0;
        end else begin
            lastWin_q <= lastWin_d;
        end
    end

    assign lastWinSel = lastWin_q;
`else
    assign lastWinSel = 1'b0;
`endif

    mem_arb_pick uPick (
        .req_i      (reqVec),
        .last_win_i (lastWinSel),
        .gnt_o      (gnt)
    );

    assign if_gnt = gnt[REQ_IF];
    assign d_gnt  = gnt[REQ_D];

    // Grant-cycle memory drive; everything is zero when nobody is granted.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (gnt[REQ_D]) begin
            mem_read  = ~d_we;
            mem_write = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner_d   = d_we ? OWN_DWR : OWN_DRD;
        end else if (gnt[REQ_IF]) begin
            mem_read  = 1'b1;
            mem_addr  = if_addr;
            mem_wdata = d_wdata;
            owner_d   = OWN_IF;
        end
    end

    // Saturating contention counter.
    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;

    // Response cycle: the owner recorded at the last edge picks up the
    // registered memory data; a completed store returns zero data.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        case (owner_q)
            OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            OWN_DRD: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            OWN_DWR: begin
                d_rvalid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a default-width instance plus a
// CNT_W = 4 instance sharing the same inputs for the saturation case, and a
// small word memory that behaves like Mem (registered read data).
module tb_mem_port_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [CNT_W-1:0]  conflict_cnt;

    logic              s4IfGnt, s4IfRvalid, s4DGnt, s4DRvalid;
    logic [DATA_W-1:0] s4IfRdata, s4DRdata, s4MemWdata;
    logic              s4MemRead, s4MemWrite;
    logic [ADDR_W-1:0] s4MemAddr;
    logic [3:0]        s4Cnt;

    logic [DATA_W-1:0] memArray [0:(1<<ADDR_W)-1];

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(s4IfGnt),
        .if_rvalid(s4IfRvalid), .if_rdata(s4IfRdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s4DGnt), .d_rvalid(s4DRvalid), .d_rdata(s4DRdata),
        .mem_read(s4MemRead), .mem_write(s4MemWrite), .mem_addr(s4MemAddr),
        .mem_wdata(s4MemWdata), .mem_rdata(mem_rdata),
        .conflict_cnt(s4Cnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: writes land at the edge, read data is registered.
    always @(posedge clk) begin
        if (mem_write) begin
            memArray[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_read ? memArray[mem_addr] : '0;
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [ADDR_W-1:0] ifAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [ADDR_W-1:0] dAddr,
                                 input logic [DATA_W-1:0] dWdata);
        if_req  = ifReq;
        if_addr = ifAddr;
        d_req   = dReq;
        d_we    = dWe;
        d_addr  = dAddr;
        d_wdata = dWdata;
    endtask

    task automatic doReset;
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        nextCycle();
        rst = 1'b1;
    endtask

    // Reset state with both requests high: nothing may be granted.
    task automatic test_reset;
        rst = 1'b0;
        applyStimulus(1'b1, 7'h08, 1'b1, 1'b0, 7'h40, 32'h0);
        @(negedge clk);
        total++;
        if ({if_gnt, d_gnt, mem_read, mem_write} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_grants: got %b want 0000", {if_gnt, d_gnt, mem_read, mem_write});
        end
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_rvalid: got %b want 00", {if_rvalid, d_rvalid});
        end
        @(negedge clk);
        total++;
        if (conflict_cnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_cnt: got %0d want 0", conflict_cnt);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_addr, mem_wdata} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL idle_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_fetch_only;
        nextCycle();
        applyStimulus(1'b1, 7'h08, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({if_gnt, d_gnt, mem_read, mem_write, mem_addr} !== {4'b1010, 7'h08}) begin
            bad++;
            $display("[TB] FAIL fetch_grant: got gnt/rd/wr %b addr %h want 1010 08",
                     {if_gnt, d_gnt, mem_read, mem_write}, mem_addr);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h00A00093}) begin
            bad++;
            $display("[TB] FAIL fetch_resp: got rv %b data %h want 10 00a00093",
                     {if_rvalid, d_rvalid}, if_rdata);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if ({if_rvalid, if_rdata} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL fetch_quiet: got rv %b data %h want 0 0", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_back_to_back;
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 7'h40, 32'hDEADBEEF);
        @(negedge clk);
        total++;
        if ({d_gnt, if_gnt, mem_write, mem_read, mem_addr, mem_wdata} !==
            {4'b1010, 7'h40, 32'hDEADBEEF}) begin
            bad++;
            $display("[TB] FAIL store_grant: got %b addr %h wdata %h want 1010 40 deadbeef",
                     {d_gnt, if_gnt, mem_write, mem_read}, mem_addr, mem_wdata);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 7'h40, 32'h0);
        @(negedge clk);
        total++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL store_resp: got rv %b data %h want 1 0", d_rvalid, d_rdata);
        end
        total++;
        if ({d_gnt, mem_read, mem_write} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL load_grant: got %b want 110", {d_gnt, mem_read, mem_write});
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({d_rvalid, if_rvalid, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("[TB] FAIL load_resp: got rv %b data %h want 10 deadbeef",
                     {d_rvalid, if_rvalid}, d_rdata);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if ({d_rvalid, d_rdata} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL load_quiet: got rv %b data %h want 0 0", d_rvalid, d_rdata);
        end
    endtask

    // Grant a fetch, then pull reset before the response is consumed.
    task automatic test_reset_mid_response;
        nextCycle();
        applyStimulus(1'b1, 7'h08, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_grant: got %b want 1", if_gnt);
        end
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_in_reset: got if_rvalid %b want 0", if_rvalid);
        end
        nextCycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({if_rvalid, d_rvalid, conflict_cnt} !== 18'd0) begin
                bad++;
                $display("[TB] FAIL midrst_after_%0d: got rv %b cnt %0d want 00 0",
                         i, {if_rvalid, d_rvalid}, conflict_cnt);
            end
            nextCycle();
        end
    endtask

    // Four cycles of continuous contention: data load at 0x40, fetch at 0x08.
    task automatic test_conflict;
        logic [3:0] expD;
        logic       prevD;
`ifdef MEM_ARB_RR_EN
        expD = 4'b0101;
`else
        expD = 4'b1111;
`endif
        prevD = 1'b0;
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 7'h08, 1'b1, 1'b0, 7'h40, 32'h0);
            @(negedge clk);
            total++;
            if ({d_gnt, if_gnt} !== {expD[k], ~expD[k]}) begin
                bad++;
                $display("[TB] FAIL conflict_gnt_%0d: got d/if %b want %b", k,
                         {d_gnt, if_gnt}, {expD[k], ~expD[k]});
            end
            if (k > 0) begin
                total++;
                if ({d_rvalid, if_rvalid, d_rdata | if_rdata} !==
                    {prevD, ~prevD, (prevD ? 32'hDEADBEEF : 32'h00A00093)}) begin
                    bad++;
                    $display("[TB] FAIL conflict_resp_%0d: got d/if rv %b data %h", k,
                             {d_rvalid, if_rvalid}, d_rdata | if_rdata);
                end
            end
            prevD = expD[k];
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({d_rvalid, if_rvalid} !== {prevD, ~prevD}) begin
            bad++;
            $display("[TB] FAIL conflict_last_resp: got d/if rv %b want %b",
                     {d_rvalid, if_rvalid}, {prevD, ~prevD});
        end
        total++;
        if (conflict_cnt !== 16'd4) begin
            bad++;
            $display("[TB] FAIL conflict_cnt: got %0d want 4", conflict_cnt);
        end
    endtask

    task automatic test_saturation;
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 7'h08, 1'b1, 1'b0, 7'h40, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (s4Cnt !== 4'hF) begin
            bad++;
            $display("[TB] FAIL sat_cnt4: got %h want f", s4Cnt);
        end
        total++;
        if (conflict_cnt !== 16'd20) begin
            bad++;
            $display("[TB] FAIL sat_cnt16: got %0d want 20", conflict_cnt);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (s4Cnt !== 4'hF) begin
            bad++;
            $display("[TB] FAIL sat_hold: got %h want f", s4Cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            memArray[i] = '0;
        end
        memArray[8] = 32'h00A00093;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        $display("[TB] starting mem_port_arbiter bench");
        test_reset();
        test_fetch_only();
        test_back_to_back();
        test_reset_mid_response();
        test_conflict();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
